// File: rtl/clock_divider_ctrl_pkg.sv
// Shared types and defaults for the programmable clock-divider controller.
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned DEFAULT_HALF_DEF = 5;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] half;
        logic                 en;
    } cfg_t;

endpackage

// File: rtl/clock_divider_ctrl_if.sv
// Valid/ready configuration port of the clock-divider controller.
interface clock_divider_ctrl_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_en;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_chan, cfg_half, cfg_en,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_half, cfg_en,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clock_div_channel.sv
// One divider channel: active/shadow config, half-period counter and
// glitch-free apply of shadowed updates at full-period boundaries.
module clock_div_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wr,
    input  cfg_t i_cfg,
    output logic o_div_clk,
    output logic o_tick,
    output logic o_pending
);

    cfg_t                 r_act;
    cfg_t                 r_shd;
    logic [CNT_W_DEF-1:0] r_cnt;
    logic                 r_div;
    logic                 r_tick;
    logic                 r_pend;

    logic w_last;
    logic w_apply;

    assign w_last  = (r_cnt == (r_act.half - 1'b1));
    // A disabled channel takes its update at once; a running one waits for the falling toggle.
    assign w_apply = r_pend && (!r_act.en || (w_last && r_div));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act  <= '{half: CNT_W_DEF'(DEFAULT_HALF), en: 1'b0};
            r_shd  <= '{half: CNT_W_DEF'(DEFAULT_HALF), en: 1'b0};
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_tick <= 1'b0;
            r_pend <= 1'b0;
        end else if (w_apply) begin
            r_act  <= r_shd;
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (i_wr) begin
                r_shd  <= i_cfg;
                r_pend <= 1'b1;
            end
            if (!r_act.en) begin
                r_cnt  <= '0;
                r_div  <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_last) begin
                r_cnt  <= '0;
                r_div  <= ~r_div;
                r_tick <= ~r_div;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end
    end

    assign o_div_clk = r_div;
    assign o_tick    = r_tick;
    assign o_pending = r_pend;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Multi-channel programmable clock divider: config decode, error check,
// ready mux and NUM_CH divider channels.
module clock_divider_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clock_divider_ctrl_if.slave  cfg,
    output logic [NUM_CH-1:0]    div_clk,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    pending
);

    logic              w_chan_ok;
    logic              w_half_ok;
    logic              w_ready;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_wr;
    cfg_t              w_cfg;
    logic              r_err;

    assign w_chan_ok = (32'(cfg.cfg_chan) < NUM_CH);
    assign w_half_ok = (cfg.cfg_half != '0);
    assign w_cfg     = '{half: CNT_W_DEF'(cfg.cfg_half), en: cfg.cfg_en};

    // Out-of-range channels are always ready so the error can be reported.
    always_comb begin
        w_ready = 1'b1;
        if (w_chan_ok) begin
            w_ready = ~pending[cfg.cfg_chan];
        end
    end

    assign w_xfer        = cfg.cfg_valid && w_ready;
    assign cfg.cfg_ready = w_ready;

    always_comb begin
        w_wr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_wr[i] = w_xfer && w_chan_ok && w_half_ok && (32'(cfg.cfg_chan) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer && !(w_chan_ok && w_half_ok);
        end
    end

    assign cfg.cfg_err = r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_div_channel #(
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr      (w_wr[g]),
            .i_cfg     (w_cfg),
            .o_div_clk (div_clk[g]),
            .o_tick    (tick[g]),
            .o_pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Self-checking bench for clock_divider_ctrl: period-position reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_clock_divider_ctrl;

    localparam int NCH  = 5;
    localparam int CW   = 16;
    localparam int HDEF = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0] div_clk, tick, pending;

    clock_divider_ctrl_if #(.NUM_CH(NCH), .CNT_W(CW)) cif ();

    clock_divider_ctrl #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .DEFAULT_HALF (HDEF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cif),
        .div_clk (div_clk),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: each channel tracks its position p within a 2H-cycle period.
    int m_h[NCH], m_p[NCH], m_sh_h[NCH];
    bit m_en[NCH], m_pend[NCH], m_sh_en[NCH];
    bit m_err;

    function automatic bit m_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic model_step();
        int ch;
        bit xfer, bad;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_h[i] = HDEF; m_p[i] = 0; m_en[i] = 0;
                m_pend[i] = 0; m_sh_h[i] = HDEF; m_sh_en[i] = 0;
            end
            m_err = 0;
        end else begin
            ch   = int'(cif.cfg_chan);
            xfer = cif.cfg_valid && m_ready(ch);
            bad  = (ch >= NCH) || (cif.cfg_half == 0);
            for (int i = 0; i < NCH; i++) begin
                if (m_pend[i] && (!m_en[i] || m_p[i] == 2 * m_h[i] - 1)) begin
                    m_h[i] = m_sh_h[i]; m_en[i] = m_sh_en[i];
                    m_p[i] = 0; m_pend[i] = 0;
                end else if (m_en[i]) begin
                    m_p[i] = (m_p[i] + 1) % (2 * m_h[i]);
                end else begin
                    m_p[i] = 0;
                end
            end
            if (xfer && !bad) begin
                m_sh_h[ch] = int'(cif.cfg_half); m_sh_en[ch] = cif.cfg_en; m_pend[ch] = 1;
            end
            m_err = xfer && bad;
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        logic [NCH-1:0] e_div, e_tick, e_pend;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                e_div[i]  = m_en[i] && (m_p[i] >= m_h[i]);
                e_tick[i] = m_en[i] && (m_p[i] == m_h[i]);
                e_pend[i] = m_pend[i];
            end
            check("model_div_clk", 32'(div_clk), 32'(e_div));
            check("model_tick", 32'(tick), 32'(e_tick));
            check("model_pending", 32'(pending), 32'(e_pend));
            check("model_cfg_ready", 32'(cif.cfg_ready), 32'(m_ready(int'(cif.cfg_chan))));
            check("model_cfg_err", 32'(cif.cfg_err), 32'(m_err));
        end
    end

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic cfg_write(input int ch, input int h, input bit en, output int waits);
        waits = 0;
        cif.cfg_valid = 1'b1;
        cif.cfg_chan  = 3'(ch);
        cif.cfg_half  = 16'(h);
        cif.cfg_en    = en;
        while (!cif.cfg_ready && waits < 100) begin
            at_edge();
            waits++;
        end
        if (!cif.cfg_ready) begin
            checks++;
            failures++;
            $display("FAIL cfg_write_timeout ch=%0d ready=0 required=1", ch);
        end
        at_edge();
        cif.cfg_valid = 1'b0;
    endtask

    initial begin
        int w, w2;
        bit t1_div[10], t1_tick[10];
        bit t2_div[6], t2_tick[6], t2_pend[6];
        t1_div  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        t1_tick = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        t2_div  = '{1, 0, 1, 0, 1, 0};
        t2_tick = '{0, 0, 1, 0, 1, 0};
        t2_pend = '{1, 0, 0, 0, 0, 0};

        cif.cfg_valid = 1'b0;
        cif.cfg_chan  = '0;
        cif.cfg_half  = '0;
        cif.cfg_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        repeat (100) at_edge();
        check("idle_div_clk", 32'(div_clk), 0);
        check("idle_tick", 32'(tick), 0);
        check("idle_pending", 32'(pending), 0);
        check("idle_cfg_ready", 32'(cif.cfg_ready), 1);

        // Ch0 H=3 from disabled: rise 3 cycles after apply, period 6
        cfg_write(0, 3, 1'b1, w);
        check("ch0_pending_after_write", 32'(pending[0]), 1);
        check("ch0_ready_after_write", 32'(cif.cfg_ready), 0);
        for (int k = 0; k < 10; k++) begin
            at_edge();
            check("ch0_h3_div", 32'(div_clk[0]), 32'(t1_div[k]));
            check("ch0_h3_tick", 32'(tick[0]), 32'(t1_tick[k]));
        end

        // Mid-high-phase switch to H=1, applied at the falling boundary
        cfg_write(0, 1, 1'b1, w);
        check("ch0_h1_pending", 32'(pending[0]), 1);
        check("ch0_h1_ready", 32'(cif.cfg_ready), 0);
        for (int k = 0; k < 6; k++) begin
            at_edge();
            check("ch0_h1_div", 32'(div_clk[0]), 32'(t2_div[k]));
            check("ch0_h1_tick", 32'(tick[0]), 32'(t2_tick[k]));
            check("ch0_h1_pend", 32'(pending[0]), 32'(t2_pend[k]));
        end

        // Invalid requests
        cfg_write(2, 0, 1'b1, w);
        check("err_half0_pulse", 32'(cif.cfg_err), 1);
        check("err_half0_ch2_pending", 32'(pending[2]), 0);
        at_edge();
        check("err_half0_clear", 32'(cif.cfg_err), 0);
        cif.cfg_chan = 3'(NCH);
        check("bad_chan_ready", 32'(cif.cfg_ready), 1);
        cfg_write(NCH, 7, 1'b1, w);
        check("err_chan_pulse", 32'(cif.cfg_err), 1);
        at_edge();
        check("err_chan_clear", 32'(cif.cfg_err), 0);
        check("err_ch2_div", 32'(div_clk[2]), 0);

        // Ch1 H=4 then disable; a follow-up write is held off while pending
        cfg_write(1, 4, 1'b1, w);
        repeat (12) at_edge();
        cfg_write(1, 4, 1'b0, w);
        cfg_write(1, 2, 1'b1, w2);
        check("ch1_second_write_held", 32'(w2 > 0), 1);
        repeat (20) at_edge();

        // Ch3 pending update, then asynchronous reset mid-period
        cfg_write(3, 2, 1'b1, w);
        repeat (3) at_edge();
        cfg_write(3, 6, 1'b1, w);
        check("ch3_pending_before_reset", 32'(pending[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_div_clk", 32'(div_clk), 0);
        check("async_rst_tick", 32'(tick), 0);
        check("async_rst_pending", 32'(pending), 0);
        check("async_rst_cfg_err", 32'(cif.cfg_err), 0);
        at_edge();
        rst_n = 1'b1;
        repeat (20) at_edge();
        check("post_rst_div_clk", 32'(div_clk), 0);
        check("post_rst_pending", 32'(pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_divider_ctrl.md
Name: clock_divider_ctrl

Overview:
- Multi-channel programmable clock-divider controller. NUM_CH independent divider channels, each producing a 50%-duty divided clock and a one-cycle tick.
- Channels are reconfigured at run time through a valid/ready config port.
- Updates are shadowed and applied only at full-period boundaries, so no output ever glitches or produces a runt pulse.
- Replaces fixed compile-time dividers wherever software-tunable timebases are needed (UART baud, LED scan, sampling strobes).

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 16, width of the half-period count; max half period = 2^CNT_W-1 cycles.
- DEFAULT_HALF, 5, half-period loaded into every channel at reset (in clk cycles).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config accept; combinational = ~pending[cfg_chan].
- cfg_chan  in  $clog2(NUM_CH) (min 1)  target channel; values >= NUM_CH are invalid.
- cfg_half  in  CNT_W  new half-period in cycles; must be >= 1.
- cfg_en  in  1  new enable for the channel.
- cfg_err  out  1  one-cycle pulse: accepted request was invalid (cfg_half==0 or cfg_chan>=NUM_CH); no state change.
- div_clk  out  NUM_CH  divided clock per channel, registered.
- tick  out  NUM_CH  one-cycle pulse per channel, coincident with each div_clk rising edge.
- pending  out  NUM_CH  shadow update waiting per channel.

Behaviour:
- Reset (async, rst_n=0):
  - div_clk=0, tick=0, pending=0, cfg_err=0.
  - All counters=0, all enables=0, all half registers=DEFAULT_HALF.
- Per-channel counter, when enabled with active half H:
  - Counts 0..H-1. At H-1 the counter returns to 0 and div_clk toggles.
  - Full period = 2H cycles.
  - tick=1 in the cycle where div_clk becomes 1; registered, same edge as div_clk.
- Disabled channel: counter held 0, div_clk=0, tick=0.
- Handshake:
  - Transfer when cfg_valid && cfg_ready.
  - Valid transfer: shadow half/en captured, pending[chan] set next cycle.
  - Invalid transfer: cfg_err pulses the next cycle and no shadow is written.
  - For an invalid cfg_chan, cfg_ready is 1.
- Apply point for pending update:
  - If the channel is enabled: at the boundary cycle where counter==H-1 and div_clk==1, i.e. the falling toggle ending a full period.
    - New H and en take effect and the counter restarts at 0 with div_clk=0.
    - If new en=0 the channel stays low.
  - If the channel is disabled: the next cycle after capture.
    - Counter starts at 0 and div_clk=0.
    - First rising edge and tick occur H cycles later.
  - pending clears on the apply cycle. cfg_ready for that channel returns 1 the following cycle.
- Simultaneous events:
  - A transfer in the same cycle as that channel's boundary is not applied at that boundary; it waits for the next one.
  - Transfers to different channels are independent, one per cycle.
- Rewriting the same values is legal and costs one boundary wait.
- H=1 gives div_clk = clk/2 with tick every 2 cycles.
- Counter never exceeds H-1. Compare uses the active register only, never the shadow.
- Reset mid-operation: immediate clear; pending updates are discarded.

Decomposition:
- Package clkdiv_pkg: CNT_W default, DEFAULT_HALF, and a cfg struct/typedef {half, en} shared by the controller and the channel.
- Sub-module clock_div_channel: one channel containing the active/shadow registers, counter, div_clk/tick generation and apply logic.
- clock_divider_ctrl instantiates NUM_CH channels and performs the cfg decode, error check and ready mux.

Test Plan:
- Reset release, no config: all div_clk/tick stay 0 for 100 cycles; pending=0, cfg_ready=1.
- Ch0 write H=3, en=1 while disabled: div_clk[0] rises 3 cycles after the apply cycle, then period 6 cycles. tick[0] is a 1-cycle pulse every 6 cycles.
- Ch0 running at H=3, write H=1 mid-high-phase:
  - pending[0]=1 and cfg_ready=0 for ch0 until the falling boundary.
  - After the boundary, period is 2 cycles.
  - No high or low phase is shorter than 1 cycle or longer than 3 cycles.
- Write to ch2 with cfg_half=0 and write to cfg_chan=NUM_CH: each gives a single cfg_err pulse; ch2 state is unchanged.
- Ch1 running at H=4, write en=0: div_clk[1] completes the current period, falls at the boundary and stays 0. A second write issued during pending is held off by cfg_ready=0.
- Assert rst_n=0 mid-period with pending set on ch3: all outputs are 0 immediately (asynchronously). After release, ch3 is disabled with H=DEFAULT_HALF.
